// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the receive-side capture FSM encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } cap_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; write is dropped when full unless a pop frees the slot.
// Outputs suffixed _c are combinational; level_o is registered.
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [LVL_W-1:0] level_o,
  output logic [LVL_W-1:0] level_nxt_c
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q;
  logic             push, pop;

  // Pop is evaluated first so a full FIFO can accept a write in the same cycle.
  always_comb begin
    full_c      = (level_q == LVL_W'(DEPTH));
    empty_c     = (level_q == '0);
    pop         = rd_en_i & ~empty_c;
    push        = wr_en_i & (~full_c | pop);
    level_nxt_c = level_q + LVL_W'(push) - LVL_W'(pop);
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    rd_data_c   = empty_c ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_nxt_c;
    end
  end

  // Storage is not reset; contents behind an empty FIFO are never presented.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Captures bytes from uart_rx via its rdy/rdy_clr handshake into a FWFT FIFO with
// level, almost-full and sticky overrun status for a valid/ready consumer.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_LVL = 12,
  localparam int unsigned LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic                   clk_50m,
  input  logic                   rst_n,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_rdy,
  output logic                   rx_rdy_clr,
  output logic [UART_DATA_W-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [LVL_W-1:0]       rx_level,
  output logic                   rx_afull,
  output logic                   rx_ovr,
  input  logic                   ovr_clr
);

  cap_state_e       state_q, state_d;
  logic             rdy_clr_q, rdy_clr_d;
  logic             rdy_hold_q, rdy_hold_d;
  logic             ovr_q, ovr_d;
  logic             afull_q, afull_d;
  logic             valid_q, valid_d;
  logic             capture_c, drop_c;
  logic             full_c, empty_c;
  logic [LVL_W-1:0] level_nxt_c;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk_i       (clk_50m),
    .rst_ni      (rst_n),
    .wr_en_i     (capture_c),
    .wr_data_i   (rx_data),
    .rd_en_i     (m_ready),
    .rd_data_c   (m_data),
    .full_c      (full_c),
    .empty_c     (empty_c),
    .level_o     (rx_level),
    .level_nxt_c (level_nxt_c)
  );

  // rdy_hold blocks a second capture while one rdy assertion is still held high.
  always_comb begin
    state_d    = state_q;
    rdy_clr_d  = 1'b0;
    rdy_hold_d = rx_rdy ? rdy_hold_q : 1'b0;
    capture_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_rdy && !rdy_hold_q) begin
          capture_c  = 1'b1;
          rdy_clr_d  = 1'b1;
          rdy_hold_d = 1'b1;
          state_d    = CLEAR;
        end
      end
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    drop_c  = capture_c & full_c & ~(m_ready & ~empty_c);
    ovr_d   = drop_c | (ovr_q & ~ovr_clr);
    afull_d = (level_nxt_c >= LVL_W'(AFULL_LVL));
    valid_d = (level_nxt_c != '0);
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rdy_clr_q  <= 1'b0;
      rdy_hold_q <= 1'b0;
      ovr_q      <= 1'b0;
      afull_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_clr_q  <= rdy_clr_d;
      rdy_hold_q <= rdy_hold_d;
      ovr_q      <= ovr_d;
      afull_q    <= afull_d;
      valid_q    <= valid_d;
    end
  end

  assign rx_rdy_clr = rdy_clr_q;
  assign rx_ovr     = ovr_q;
  assign rx_afull   = afull_q;
  assign m_valid    = valid_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue model of the byte buffer checked every cycle.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int LVL_W = 5;

  logic             clk_50m = 1'b0;
  logic             rst_n;
  logic [7:0]       rx_data;
  logic             rx_rdy;
  logic             rx_rdy_clr;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_ready;
  logic [LVL_W-1:0] rx_level;
  logic             rx_afull;
  logic             rx_ovr;
  logic             ovr_clr;

  always #10 clk_50m = ~clk_50m;

  uart_rx_fifo #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .rx_rdy_clr (rx_rdy_clr),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .rx_level   (rx_level),
    .rx_afull   (rx_afull),
    .rx_ovr     (rx_ovr),
    .ovr_clr    (ovr_clr)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  exp_q[$];
  bit          exp_ovr;
  bit          exp_clr;
  bit          rdy_prev;
  bit          phase_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one byte per rising rdy, stored unless the buffer is full.
  always @(posedge clk_50m or negedge rst_n) begin
    bit cap;
    bit drop;
    if (!rst_n) begin
      exp_q.delete();
      exp_ovr  = 1'b0;
      exp_clr  = 1'b0;
      rdy_prev = 1'b0;
    end else begin
      cap      = rx_rdy && !rdy_prev;
      rdy_prev = rx_rdy;
      exp_clr  = cap;
      drop     = 1'b0;
      if (cap) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(rx_data);
        else drop = 1'b1;
      end
      if (drop) exp_ovr = 1'b1;
      else if (ovr_clr) exp_ovr = 1'b0;
    end
  end

  // Monitor: compare all outputs mid-cycle, then retire the head if the consumer takes it.
  always @(negedge clk_50m) begin
    #1;
    chk("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("m_data", 32'(m_data), 32'(exp_q[0]));
    if (!rst_n) chk("m_data_rst", 32'(m_data), 32'h0);
    chk("rx_level", 32'(rx_level), 32'(exp_q.size()));
    chk("rx_afull", 32'(rx_afull), 32'(exp_q.size() >= AFULL));
    chk("rx_ovr", 32'(rx_ovr), 32'(exp_ovr));
    chk("rx_rdy_clr", 32'(rx_rdy_clr), 32'(exp_clr));
    if (rst_n && m_ready && exp_q.size() != 0) void'(exp_q.pop_front());
  end

  task automatic send(input logic [7:0] b, input int hold, input bit clr, input bit pop);
    @(negedge clk_50m);
    rx_data = b;
    rx_rdy  = 1'b1;
    ovr_clr = clr;
    if (pop) m_ready = 1'b1;
    @(negedge clk_50m);
    ovr_clr = 1'b0;
    if (pop) m_ready = 1'b0;
    repeat (hold - 1) @(negedge clk_50m);
    rx_rdy = 1'b0;
    @(negedge clk_50m);
  endtask

  task automatic drain();
    @(negedge clk_50m);
    m_ready = 1'b1;
    repeat (DEPTH + 3) @(negedge clk_50m);
    m_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    rx_data = 8'h00;
    rx_rdy  = 1'b0;
    m_ready = 1'b0;
    ovr_clr = 1'b0;
    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50m);

    // Single byte with rdy held past the clear cycle.
    send(8'hA5, 3, 1'b0, 1'b0);
    repeat (2) @(negedge clk_50m);
    drain();

    // Fill to full, then overrun behaviour.
    for (int i = 0; i < DEPTH; i++) send(8'(i), 2, 1'b0, 1'b0);
    send(8'hEE, 2, 1'b0, 1'b0);
    send(8'hEE, 2, 1'b1, 1'b0);
    @(negedge clk_50m);
    ovr_clr = 1'b1;
    @(negedge clk_50m);
    ovr_clr = 1'b0;
    // Full with capture and pop together.
    send(8'hEE, 2, 1'b0, 1'b1);
    repeat (2) @(negedge clk_50m);
    drain();

    // Streaming through pointer wrap with the consumer toggling.
    phase_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(8'($urandom), int'($urandom_range(1, 3)), 1'b0, 1'b0);
        phase_done = 1'b1;
      end
      begin
        for (int c = 0; c < 1000 && !phase_done; c++) begin
          @(negedge clk_50m);
          m_ready = ~m_ready;
        end
      end
    join
    m_ready = 1'b0;
    drain();

    // Mostly-stalled consumer with random overrun clears.
    phase_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++)
          send(8'($urandom), int'($urandom_range(1, 3)), ($urandom_range(0, 7) == 0), 1'b0);
        phase_done = 1'b1;
      end
      begin
        for (int c = 0; c < 2000 && !phase_done; c++) begin
          @(negedge clk_50m);
          m_ready = ($urandom_range(0, 3) == 0);
        end
      end
    join
    m_ready = 1'b0;
    drain();
    @(negedge clk_50m);
    ovr_clr = 1'b1;
    @(negedge clk_50m);
    ovr_clr = 1'b0;

    // Reset asserted mid-cycle while a capture's clear pulse is active.
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), 2, 1'b0, 1'b0);
    @(negedge clk_50m);
    rx_data = 8'h77;
    rx_rdy  = 1'b1;
    @(posedge clk_50m);
    #3;
    rst_n  = 1'b0;
    rx_rdy = 1'b0;
    #1;
    chk("rst_rdy_clr", 32'(rx_rdy_clr), 32'h0);
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_m_data", 32'(m_data), 32'h0);
    chk("rst_level", 32'(rx_level), 32'h0);
    chk("rst_afull", 32'(rx_afull), 32'h0);
    chk("rst_ovr", 32'(rx_ovr), 32'h0);
    repeat (2) @(negedge clk_50m);
    rst_n = 1'b1;
    repeat (6) @(negedge clk_50m);
    #2;
    chk("post_rst_rdy_clr", 32'(rx_rdy_clr), 32'h0);
    chk("post_rst_level", 32'(rx_level), 32'h0);

    // Normal operation resumes after reset.
    send(8'h5A, 2, 1'b0, 1'b0);
    repeat (2) @(negedge clk_50m);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
